if_stage_fetch: RTL
===================

# if_stage_fetch

Instruction-fetch stage with integrated IF/ID pipeline register, sitting directly upstream of the decode stage and of the hazard detector. It owns the PC, issues requests to instruction memory over a req/ack handshake that tolerates wait states, and presents the fetched instruction and its PC+4 to decode. It consumes the hazard detector's stall output as `freeze`, and the execute stage's branch-taken signal as a flush/redirect.

## Interface
- `ADDR_W`, 32, PC and memory address width
- `INSTR_W`, 32, instruction width
- `RESET_PC`, 0, PC value after reset
- `PC_STEP`, 4, PC increment per instruction

- `clk` in 1: single clock; all state updates on the rising edge
- `rst` in 1: reset, synchronous and active-high
- `freeze` in 1: stall from the hazard detector; hold the PC and IF/ID
- `branch_taken` in 1: redirect from execute; single-cycle pulse
- `branch_addr` in ADDR_W: redirect target
- `imem_req` out 1: fetch request
- `imem_addr` out ADDR_W: fetch address
- `imem_rdata` in INSTR_W: instruction; valid in the cycle `imem_ack`=1
- `imem_ack` in 1: memory completion; may be asserted in the same cycle as `imem_req` (zero-wait)
- `ifid_pc` out ADDR_W: PC+PC_STEP of the instruction held in IF/ID
- `ifid_instr` out INSTR_W: instruction held in IF/ID
- `ifid_valid` out 1: the IF/ID contents are a real instruction (0 means bubble)

## Operation
- Registers:
  - `pc`
  - `state` ∈ {FETCH, HOLD, DROP}
  - hold buffer (`hb_pc`, `hb_instr`)
  - IF/ID (`ifid_*`)
- `imem_req` = 1 in FETCH and DROP, 0 in HOLD.
- `imem_addr` = `pc` in FETCH. In DROP it is the stale address latched at redirect.
- Request rule: once asserted, `imem_req` and `imem_addr` stay stable until `imem_ack`. The one exception is `rst`, which abandons the request; the memory must accept this.
- Priority per cycle: `rst` > `branch_taken` > `freeze` > normal.
- FETCH, ack, no freeze:
  - IF/ID ← {pc+PC_STEP, imem_rdata, 1}
  - pc ← pc+PC_STEP
- FETCH, ack, freeze:
  - hb ← {pc+PC_STEP, imem_rdata}
  - pc ← pc+PC_STEP
  - IF/ID unchanged
  - → HOLD
- FETCH, no ack, no freeze: IF/ID ← bubble ({0,0,0}).
- FETCH, no ack, freeze: IF/ID unchanged.
- HOLD while freeze=1: everything held, no request issued.
- HOLD when freeze=0:
  - IF/ID ← {hb_pc, hb_instr, 1}
  - → FETCH (the request for the new pc starts the next cycle)
- Branch with ack in the same cycle, or branch in HOLD:
  - pc ← branch_addr
  - IF/ID ← bubble
  - any hold-buffer or acked data is discarded
  - → FETCH
  - This applies regardless of `freeze`.
- Branch while FETCH, no ack:
  - pc ← branch_addr
  - IF/ID ← bubble
  - stale address latched
  - → DROP
- DROP, ack: data is discarded; → FETCH. IF/ID stays a bubble unless freeze=1 (then held).
- DROP, no ack: stays in DROP.
- A branch arriving while in DROP: the new target replaces `pc`; the state stays DROP.
- PC arithmetic is modulo 2^ADDR_W; wrap from all-ones is silent.

## Timing
- Reset values:
  - `pc`=RESET_PC, state=FETCH
  - `ifid_pc`=0, `ifid_instr`=0, `ifid_valid`=0
  - hold buffer = 0
  - `imem_req`=0 while `rst`=1, and 1 in the first cycle after release
- Zero-wait memory: one instruction per cycle; the instruction appears on `ifid_*` one edge after its ack.
- N wait states: N bubbles are inserted into IF/ID (when not frozen).
- `freeze` is sampled every edge. A freeze of k cycles holds IF/ID for exactly k edges; the first new IF/ID value follows the first edge with freeze=0.
- Branch: the first request to `branch_addr` is issued the cycle after the pulse (FETCH/HOLD path), or the cycle after the stale ack (DROP path).
- Redirect penalty: at least 1 bubble.
- Reset mid-DROP or mid-HOLD: all state is discarded; behaviour is the same as a cold reset.

## Test plan
- Reset and zero-wait streaming:
  - Stimulus: `rst` for 2 cycles, then ack every cycle with rdata=0xE000_0000+addr.
  - Required: imem_addr = 0,4,8,…; ifid_pc = 4,8,12,… one cycle later; ifid_valid=1 continuously.
- Wait states:
  - Stimulus: ack 2 cycles after req at addr 8.
  - Required: addr 8 is held for 3 cycles; ifid_valid=0 for 2 cycles, then ifid_instr = rdata(8), ifid_pc=12.
- Freeze during ack:
  - Stimulus: freeze=1 for 3 cycles, starting in the cycle addr 0x10 is acked.
  - Required: IF/ID is unchanged for 3 edges and imem_req=0 in HOLD; then ifid_pc=0x14 with the hold instruction, and the next request goes to 0x14.
- Branch with ack in the same cycle:
  - Stimulus: branch_taken=1, branch_addr=0x100, with ack at 0x20.
  - Required: ifid_valid=0 on the next edge; the next imem_addr=0x100; the 0x20 data never appears.
- Branch with a request outstanding, plus freeze=1:
  - Stimulus: branch to 0x200 while 0x30 is unacked; ack 2 cycles later.
  - Required: 0x30 is held until ack and its data is dropped; the next request is 0x200; ifid_valid=0 throughout.
- Reset mid-HOLD and PC wrap:
  - Stimulus: (a) `rst` asserted while in HOLD; (b) RESET_PC=0xFFFF_FFFC with ack.
  - Required: (a) all outputs return to their reset values; (b) the next imem_addr=0 and ifid_pc=0.

Source files
------------

// File: rtl/if_stage_fetch.sv
`default_nettype none
// ============================================================================
// Module   : if_stage_fetch
// Purpose  : Instruction fetch with PC, req/ack memory handshake and IF/ID reg.
// Revision : 1.0  initial release
// ============================================================================
module if_stage_fetch #(
    parameter int                ADDR_W   = 32,
    parameter int                INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                PC_STEP  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               freeze,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_addr,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_ack,
    output logic [ADDR_W-1:0]  ifid_pc,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic               ifid_valid
);

    localparam logic [ADDR_W-1:0] c_pc_step = ADDR_W'(PC_STEP);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DROP  = 2'd2
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [ADDR_W-1:0]    r_pc, w_pc_nxt;
    logic [ADDR_W-1:0]    r_drop_addr, w_drop_addr_nxt;
    logic [ADDR_W-1:0]    r_hb_pc, w_hb_pc_nxt;
    logic [INSTR_W-1:0]   r_hb_instr, w_hb_instr_nxt;
    logic [ADDR_W-1:0]    r_ifid_pc, w_ifid_pc_nxt;
    logic [INSTR_W-1:0]   r_ifid_instr, w_ifid_instr_nxt;
    logic                 r_ifid_valid, w_ifid_valid_nxt;
    logic [ADDR_W-1:0]    w_pc_inc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_FETCH;
            r_pc         <= RESET_PC;
            r_drop_addr  <= '0;
            r_hb_pc      <= '0;
            r_hb_instr   <= '0;
            r_ifid_pc    <= '0;
            r_ifid_instr <= '0;
            r_ifid_valid <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_drop_addr  <= w_drop_addr_nxt;
            r_hb_pc      <= w_hb_pc_nxt;
            r_hb_instr   <= w_hb_instr_nxt;
            r_ifid_pc    <= w_ifid_pc_nxt;
            r_ifid_instr <= w_ifid_instr_nxt;
            r_ifid_valid <= w_ifid_valid_nxt;
        end
    end

    always_comb begin
        w_pc_inc         = r_pc + c_pc_step;
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_drop_addr_nxt  = r_drop_addr;
        w_hb_pc_nxt      = r_hb_pc;
        w_hb_instr_nxt   = r_hb_instr;
        w_ifid_pc_nxt    = r_ifid_pc;
        w_ifid_instr_nxt = r_ifid_instr;
        w_ifid_valid_nxt = r_ifid_valid;

        case (r_state)
            ST_FETCH: begin
                if (branch_taken) begin
                    w_pc_nxt         = branch_addr;
                    w_ifid_pc_nxt    = '0;
                    w_ifid_instr_nxt = '0;
                    w_ifid_valid_nxt = 1'b0;
                    // An unacked request must stay on the bus until memory answers.
                    if (!imem_ack) begin
                        w_state_nxt     = ST_DROP;
                        w_drop_addr_nxt = r_pc;
                    end
                end else if (imem_ack) begin
                    w_pc_nxt = w_pc_inc;
                    if (freeze) begin
                        w_hb_pc_nxt    = w_pc_inc;
                        w_hb_instr_nxt = imem_rdata;
                        w_state_nxt    = ST_HOLD;
                    end else begin
                        w_ifid_pc_nxt    = w_pc_inc;
                        w_ifid_instr_nxt = imem_rdata;
                        w_ifid_valid_nxt = 1'b1;
                    end
                end else if (!freeze) begin
                    w_ifid_pc_nxt    = '0;
                    w_ifid_instr_nxt = '0;
                    w_ifid_valid_nxt = 1'b0;
                end
            end
            ST_HOLD: begin
                if (branch_taken) begin
                    w_pc_nxt         = branch_addr;
                    w_ifid_pc_nxt    = '0;
                    w_ifid_instr_nxt = '0;
                    w_ifid_valid_nxt = 1'b0;
                    w_state_nxt      = ST_FETCH;
                end else if (!freeze) begin
                    w_ifid_pc_nxt    = r_hb_pc;
                    w_ifid_instr_nxt = r_hb_instr;
                    w_ifid_valid_nxt = 1'b1;
                    w_state_nxt      = ST_FETCH;
                end
            end
            ST_DROP: begin
                if (branch_taken) begin
                    w_pc_nxt = branch_addr;
                end
                if (branch_taken || !freeze) begin
                    w_ifid_pc_nxt    = '0;
                    w_ifid_instr_nxt = '0;
                    w_ifid_valid_nxt = 1'b0;
                end
                if (imem_ack) begin
                    w_state_nxt = ST_FETCH;
                end
            end
            default: begin
                w_state_nxt = ST_FETCH;
            end
        endcase
    end

    assign imem_req   = !rst && (r_state != ST_HOLD);
    assign imem_addr  = (r_state == ST_DROP) ? r_drop_addr : r_pc;
    assign ifid_pc    = r_ifid_pc;
    assign ifid_instr = r_ifid_instr;
    assign ifid_valid = r_ifid_valid;

endmodule
`default_nettype wire
